// File: rtl/uart_pkg.sv
// Shared constants, register map and FSM state type for the UART transmit controller.
package uart_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 862;

    localparam logic UART_DATA   = 1'b0;
    localparam logic UART_STATUS = 1'b1;

    localparam int ST_BUSY  = 31;
    localparam int ST_FULL  = 30;
    localparam int ST_EMPTY = 29;
    localparam int ST_OVR   = 28;
    localparam int ST_IE    = 25;
    localparam int ST_FLUSH = 24;

    // Start bit, eight data bits and the stop bit; bits are indexed 0..9.
    localparam logic [3:0] STOP_BIT_IDX = 4'd9;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO; pointers carry an extra wrap bit so full and empty stay distinct.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A push against a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is not reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Wishbone-mapped UART transmitter: DATA/STATUS registers, TX FIFO and an 8N1 serialiser
// that sends queued bytes back to back with no idle gap between frames.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic        adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        txd,
    output logic        irq_o
);

    localparam int unsigned BAUD_W = $clog2(CLK_DIV);
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

    logic              ack_q;
    logic [31:0]       dat_q;
    logic              ovr_q;
    logic              ie_q;
    tx_state_e         state_q;
    logic [9:0]        shreg_q;
    logic [BAUD_W-1:0] baud_q;
    logic [3:0]        bit_q;
    logic              txd_q;

    logic              access;
    logic              wr_data;
    logic              wr_status;
    logic              rd_status;
    logic              flush;
    logic              frame_end;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic [7:0]        fifo_head;
    logic [31:0]       status_word;
    logic              unused_dat;

    assign access    = cyc_i & stb_i & ~ack_q;
    assign wr_data   = access & we_i & (adr_i == UART_DATA);
    assign wr_status = access & we_i & (adr_i == UART_STATUS);
    assign rd_status = access & ~we_i & (adr_i == UART_STATUS);
    assign flush     = wr_status & dat_i[ST_FLUSH];
    assign unused_dat = ^dat_i[23:0];

    assign frame_end = (state_q == S_SHIFT) && (baud_q == BAUD_LAST) && (bit_q == STOP_BIT_IDX);
    assign fifo_pop  = ~fifo_empty && ((state_q == S_IDLE) || frame_end);

    uart_tx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_data),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .wdata_i (dat_i[31:24]),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        status_word           = '0;
        status_word[ST_BUSY]  = (state_q != S_IDLE) || ~fifo_empty;
        status_word[ST_FULL]  = fifo_full;
        status_word[ST_EMPTY] = fifo_empty;
        status_word[ST_OVR]   = ovr_q;
        status_word[ST_IE]    = ie_q;
        status_word[23:16]    = 8'(fifo_level);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            ovr_q <= 1'b0;
            ie_q  <= 1'b0;
        end else begin
            ack_q <= access;
            dat_q <= rd_status ? status_word : 32'd0;
            if (wr_data && fifo_full) ovr_q <= 1'b1;
            if (wr_status) begin
                ie_q <= dat_i[ST_IE];
                if (dat_i[ST_OVR]) ovr_q <= 1'b0;
            end
        end
    end

    // txd follows shreg_q[0] one cycle late, so every bit is still exactly CLK_DIV cycles wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (!fifo_empty) begin
                        shreg_q <= {1'b1, fifo_head, 1'b0};
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    txd_q <= shreg_q[0];
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == STOP_BIT_IDX) begin
                            bit_q <= '0;
                            if (!fifo_empty) shreg_q <= {1'b1, fifo_head, 1'b0};
                            else             state_q <= S_IDLE;
                        end else begin
                            shreg_q <= {1'b1, shreg_q[9:1]};
                            bit_q   <= bit_q + 4'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign txd   = txd_q;
    assign irq_o = ie_q & fifo_empty & (state_q == S_IDLE);

endmodule
